// File: rtl/serdes_mlane.sv
// serdes_mlane: multi-lane serialiser/deserialiser with start strobe, per-lane even parity and loopback
module serdes_mlane #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [LANES-1:0]  ser_out,
  output logic              start_o,
  input  logic [LANES-1:0]  ser_in,
  input  logic              start_i,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);
  localparam int B  = DATA_W / LANES;
  localparam int F  = B + PARITY_EN;
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  typedef enum logic {T_IDLE, T_SEND} tx_st_t;
  typedef enum logic {R_IDLE, R_RECV} rx_st_t;

  tx_st_t              tx_st_q, tx_st_d;
  rx_st_t              rx_st_q, rx_st_d;
  logic [CW-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [LANES*F-1:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d, rx_word;
  logic                rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic                accept, rx_last, par_err, rx_start;
  logic [LANES-1:0]    rx_src;

  // one lane's frame: data MSB first, then the even-parity bit when enabled
  function automatic logic [F-1:0] frame(input logic [B-1:0] d);
    logic [F-1:0] r;
    r = '0;
    r[F-1 -: B] = d;
    if (PARITY_EN != 0) r[0] = ^d;
    return r;
  endfunction

  assign tx_ready = (tx_st_q == T_IDLE) || (tx_cnt_q == LAST);
  assign accept   = tx_valid && tx_ready;
  assign start_o  = start_q;
  assign rx_src   = loopback ? ser_out : ser_in;
  assign rx_start = loopback ? start_o : start_i;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  // each lane drives the MSB of its own shift register; zeros shift in so idle lines read 0
  always_comb begin
    for (int k = 0; k < LANES; k++) ser_out[k] = tx_sh_q[k*F+F-1];
  end

  // TX next state: load on accept, otherwise shift through the frame and drop back to idle
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    start_d  = 1'b0;
    tx_sh_d  = tx_sh_q << 1;
    for (int k = 0; k < LANES; k++) tx_sh_d[k*F] = 1'b0;
    if (accept) begin
      tx_st_d  = T_SEND;
      tx_cnt_d = '0;
      start_d  = 1'b1;
      for (int k = 0; k < LANES; k++) tx_sh_d[k*F +: F] = frame(tx_data[k*B +: B]);
    end else if (tx_st_q == T_SEND) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
      if (tx_cnt_q == LAST) begin
        tx_st_d  = T_IDLE;
        tx_cnt_d = '0;
      end
    end
  end

  // RX next state: shift every lane in, finish the frame on its last bit and check parity
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_last  = 1'b0;
    rx_sh_d  = rx_sh_q << 1;
    for (int k = 0; k < LANES; k++) rx_sh_d[k*F] = rx_src[k];
    if (rx_st_q == R_IDLE) begin
      if (rx_start) begin
        rx_st_d  = R_RECV;
        rx_cnt_d = CW'(1);
        rx_last  = (F == 1);
      end
    end else begin
      rx_cnt_d = rx_cnt_q + 1'b1;
      rx_last  = (rx_cnt_q == LAST);
    end
    if (rx_last) begin
      rx_st_d  = R_IDLE;
      rx_cnt_d = '0;
    end
    rx_word = '0;
    par_err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      rx_word[k*B +: B] = rx_sh_d[k*F+F-1 -: B];
      par_err           = par_err | (^rx_sh_d[k*F +: F]);
    end
    rx_data_d  = rx_last ? rx_word : rx_data_q;
    rx_valid_d = rx_last;
    rx_err_d   = rx_last && (PARITY_EN != 0) && par_err;
  end

  // state registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      start_q    <= 1'b0;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      start_q    <= start_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end
endmodule
